// File: rtl/dcpu_wait_mem.sv
// Byte-addressed little-endian RAM for the dCPU bus with a configurable
// access latency, ready handshake and sticky collision/range error flags.
module dcpu_wait_mem #(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 16,
   parameter int                MEM_BYTES = 256,
   parameter int                LAT       = 2,
   parameter logic [DATA_W-1:0] IDLE_PAT  = 16'haaaa
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              R,
   input  logic              W,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              err_collide,
   output logic              err_range
);

   localparam int unsigned BPW = DATA_W / 8;
   localparam int unsigned MB  = MEM_BYTES;
   localparam int          IW  = $clog2(MEM_BYTES);

   logic [7:0]        mem_q [MEM_BYTES];
   logic              rd_op, wr_op, coll, op_v, in_rng;
   logic [ADDR_W-1:0] rd_a, wa;
   logic [DATA_W-1:0] rd_word, wd;
   logic              we;

   assign rd_op  = !R && W;
   assign wr_op  = R && !W;
   assign coll   = !R && !W;
   assign op_v   = rd_op || wr_op;
   assign in_rng = 32'(addr) <= (MB - BPW);

   function automatic logic [IW-1:0] idx(input logic [ADDR_W-1:0] a,
                                         input int unsigned i);
      int unsigned s;
      s = 32'(a) + i;
      return IW'(s % MB);
   endfunction

   always_comb begin
      rd_word = '0;
      for (int unsigned i = 0; i < BPW; i++)
         rd_word[8*i +: 8] = mem_q[idx(rd_a, i)];
   end

   // Backing store is deliberately not reset.
   always_ff @(posedge clk) begin
      if (we)
         for (int unsigned i = 0; i < BPW; i++)
            mem_q[idx(wa, i)] <= wd[8*i +: 8];
   end

   if (LAT == 0) begin : g_comb
      logic ec_q, er_q;

      assign rd_a  = addr;
      assign wa    = addr;
      assign wd    = wdata;
      assign we    = wr_op && in_rng && rst;
      assign ready = 1'b1;
      assign rdata = (rd_op && in_rng) ? rd_word : IDLE_PAT;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            ec_q <= 1'b0;
            er_q <= 1'b0;
         end else begin
            if (coll)
               ec_q <= 1'b1;
            if (op_v && !in_rng)
               er_q <= 1'b1;
         end
      end

      assign err_collide = ec_q;
      assign err_range   = er_q;
   end else begin : g_fsm
      typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
      localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

      state_e            state_q;
      logic [CW-1:0]     cnt_q;
      logic              wr_q, rng_q, ready_q, ec_q, er_q;
      logic [ADDR_W-1:0] addr_q;
      logic [DATA_W-1:0] wdata_q, rdata_q, rdata_d;
      logic              same, go_done, cw, crng;

      // In IDLE the commit (LAT==1 only) uses the live bus, else the latch.
      always_comb begin
         same    = wr_q ? wr_op : rd_op;
         go_done = 1'b0;
         cw      = wr_q;
         crng    = rng_q;
         rd_a    = addr_q;
         wd      = wdata_q;
         if (state_q == S_IDLE) begin
            cw      = wr_op;
            crng    = in_rng;
            rd_a    = addr;
            wd      = wdata;
            go_done = (LAT == 1) && op_v;
         end else if (state_q == S_BUSY) begin
            go_done = same && (cnt_q == CW'(1));
         end
      end

      assign wa      = rd_a;
      assign rdata_d = (!cw && crng) ? rd_word : IDLE_PAT;
      assign we      = go_done && cw && crng && rst;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rng_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= IDLE_PAT;
            ready_q <= 1'b0;
            ec_q    <= 1'b0;
            er_q    <= 1'b0;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (coll) begin
                     ec_q <= 1'b1;
                  end else if (op_v) begin
                     wr_q    <= wr_op;
                     addr_q  <= addr;
                     wdata_q <= wdata;
                     rng_q   <= in_rng;
                     if (!in_rng)
                        er_q <= 1'b1;
                     if (go_done) begin
                        state_q <= S_DONE;
                        ready_q <= 1'b1;
                        rdata_q <= rdata_d;
                     end else begin
                        state_q <= S_BUSY;
                        cnt_q   <= CW'(LAT - 1);
                     end
                  end
               end
               S_BUSY: begin
                  if (coll) begin
                     ec_q    <= 1'b1;
                     state_q <= S_IDLE;
                  end else if (!same) begin
                     state_q <= S_IDLE;
                  end else if (go_done) begin
                     state_q <= S_DONE;
                     ready_q <= 1'b1;
                     rdata_q <= rdata_d;
                  end else begin
                     cnt_q <= cnt_q - CW'(1);
                  end
               end
               S_DONE: begin
                  if (coll || !same) begin
                     if (coll)
                        ec_q <= 1'b1;
                     state_q <= S_IDLE;
                     ready_q <= 1'b0;
                     rdata_q <= IDLE_PAT;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end

      assign rdata       = rdata_q;
      assign ready       = ready_q;
      assign err_collide = ec_q;
      assign err_range   = er_q;
   end

endmodule

// File: tb/tb_dcpu_wait_mem.sv
// Bench for dcpu_wait_mem: four instances (LAT 0..3) against a byte-array
// reference memory with directed and random accesses.
module tb_dcpu_wait_mem;

   localparam logic [15:0] IDLE = 16'haaaa;

   logic        clk = 1'b0;
   logic        rst;
   logic        R [4];
   logic        W [4];
   logic [15:0] addr [4];
   logic [15:0] wdata [4];
   logic [15:0] rdata [4];
   logic        ready [4];
   logic        ecol [4];
   logic        erng [4];

   logic [7:0]  mem_m [4][256];
   bit          ec_m [4];
   bit          er_m [4];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      dcpu_wait_mem #(
         .DATA_W(16), .ADDR_W(16), .MEM_BYTES(256),
         .LAT(g), .IDLE_PAT(16'haaaa)
      ) dut (
         .clk(clk), .rst(rst), .R(R[g]), .W(W[g]),
         .addr(addr[g]), .wdata(wdata[g]), .rdata(rdata[g]),
         .ready(ready[g]), .err_collide(ecol[g]), .err_range(erng[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic flags(input int g);
      chk($sformatf("err_collide[%0d]", g), 32'(ecol[g]), 32'(ec_m[g]));
      chk($sformatf("err_range[%0d]", g), 32'(erng[g]), 32'(er_m[g]));
   endtask

   function automatic logic [15:0] mword(input int g, input logic [15:0] a);
      logic [7:0] lo, hi;
      lo = a[7:0];
      hi = lo + 8'd1;
      return {mem_m[g][hi], mem_m[g][lo]};
   endfunction

   // One complete bus transaction; expected timing follows LAT = g.
   task automatic access(input int g, input bit wr, input logic [15:0] a,
                         input logic [15:0] d, input int hold);
      logic [15:0] exp;
      logic [7:0]  lo;
      bit          rng;
      rng = (a <= 16'd254);
      exp = (!wr && rng) ? mword(g, a) : IDLE;
      R[g] = wr;
      W[g] = !wr;
      addr[g] = a;
      wdata[g] = d;
      if (g == 0) begin
         #1;
         chk("l0_ready", 32'(ready[0]), 32'd1);
         chk($sformatf("l0_rdata@%0h", a), 32'(rdata[0]), 32'(exp));
         @(negedge clk);
      end else begin
         for (int c = 1; c <= g; c++) begin
            @(negedge clk);
            chk($sformatf("ready_lat%0d_c%0d", g, c), 32'(ready[g]),
                32'(c == g));
         end
         chk($sformatf("rdata_done%0d@%0h", g, a), 32'(rdata[g]), 32'(exp));
         for (int h = 0; h < hold; h++) begin
            wdata[g] = 16'($urandom);
            @(negedge clk);
            chk($sformatf("ready_hold%0d", g), 32'(ready[g]), 32'd1);
            chk($sformatf("rdata_hold%0d", g), 32'(rdata[g]), 32'(exp));
         end
      end
      if (wr && rng) begin
         lo = a[7:0];
         mem_m[g][lo] = d[7:0];
         mem_m[g][lo + 8'd1] = d[15:8];
      end
      if (!rng)
         er_m[g] = 1'b1;
      R[g] = 1'b1;
      W[g] = 1'b1;
      if (g != 0) begin
         @(negedge clk);
         chk($sformatf("ready_rel%0d", g), 32'(ready[g]), 32'd0);
         chk($sformatf("rdata_rel%0d", g), 32'(rdata[g]), 32'(IDLE));
      end
      flags(g);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      for (int g = 0; g < 4; g++) begin
         R[g] = 1'b1;
         W[g] = 1'b1;
         addr[g] = '0;
         wdata[g] = '0;
         ec_m[g] = 1'b0;
         er_m[g] = 1'b0;
      end
      repeat (2) @(negedge clk);
      for (int g = 0; g < 4; g++) begin
         chk($sformatf("rst_ready%0d", g), 32'(ready[g]), 32'(g == 0));
         chk($sformatf("rst_rdata%0d", g), 32'(rdata[g]), 32'(IDLE));
         flags(g);
      end
      rst = 1'b1;
      @(negedge clk);

      for (int g = 0; g < 4; g++)
         for (int a = 0; a < 256; a += 2)
            access(g, 1'b1, 16'(a), 16'($urandom), 0);

      // legacy mode: write then same-cycle read
      access(0, 1'b1, 16'd0, 16'h1234, 0);
      access(0, 1'b0, 16'd0, 16'h0, 0);
      chk("l0_1234", 32'(mword(0, 16'd0)), 32'h1234);

      // held write must not repeat even with changing wdata
      access(2, 1'b1, 16'd4, 16'hBEEF, 3);
      access(2, 1'b0, 16'd4, 16'h0, 0);
      access(2, 1'b0, 16'd5, 16'h0, 0);

      access(3, 1'b1, 16'd4, 16'hBEEF, 0);
      access(3, 1'b0, 16'd4, 16'h0, 1);

      // abort in BUSY
      W[2] = 1'b0;
      addr[2] = 16'd4;
      wdata[2] = 16'h1111;
      @(negedge clk);
      chk("abort_busy_ready", 32'(ready[2]), 32'd0);
      W[2] = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("abort_ready", 32'(ready[2]), 32'd0);
      end
      access(2, 1'b0, 16'd4, 16'h0, 0);

      // collisions on every instance
      for (int g = 0; g < 4; g++) begin
         R[g] = 1'b0;
         W[g] = 1'b0;
         addr[g] = 16'd4;
         wdata[g] = 16'h5555;
         @(negedge clk);
         ec_m[g] = 1'b1;
         R[g] = 1'b1;
         W[g] = 1'b1;
         repeat (3) begin
            @(negedge clk);
            flags(g);
         end
         access(g, 1'b0, 16'd4, 16'h0, 0);
      end

      // reset pulse between clock edges; memory must survive
      @(negedge clk);
      #1 rst = 1'b0;
      #2 rst = 1'b1;
      for (int g = 0; g < 4; g++) begin
         ec_m[g] = 1'b0;
         er_m[g] = 1'b0;
      end
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
         flags(g);
         chk($sformatf("pulse_ready%0d", g), 32'(ready[g]), 32'(g == 0));
         access(g, 1'b0, 16'd4, 16'h0, 0);
      end

      // range boundary
      access(2, 1'b0, 16'd255, 16'h0, 0);
      access(2, 1'b0, 16'd254, 16'h0, 0);
      access(0, 1'b1, 16'd255, 16'h7777, 0);
      access(0, 1'b0, 16'd254, 16'h0, 0);

      for (int n = 0; n < 300; n++)
         access(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 259)), 16'($urandom),
                int'($urandom_range(0, 2)));

      // reset in BUSY must drop the pending write
      W[3] = 1'b0;
      addr[3] = 16'd8;
      wdata[3] = ~mword(3, 16'd8);
      @(negedge clk);
      #1 rst = 1'b0;
      W[3] = 1'b1;
      #2 rst = 1'b1;
      for (int g = 0; g < 4; g++) begin
         ec_m[g] = 1'b0;
         er_m[g] = 1'b0;
      end
      repeat (3) begin
         @(negedge clk);
         chk("midrst_ready", 32'(ready[3]), 32'd0);
      end
      access(3, 1'b0, 16'd8, 16'h0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
